// File: rtl/work_feeder.sv
// work_feeder: streams a host-loaded 40-word block header to the distribution unit over the m2d bus,
// optionally bumping the 32-bit nonce after each job so back-to-back jobs need no reload.
module work_feeder #(
    parameter int WIDTH_M2D    = 16,
    parameter int DEPTH_WORDS  = 40,
    parameter int ADDR_BITS    = 6,
    parameter int NONCE_HI_IDX = 38,
    parameter int AUTO_INC     = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 host_we_i,
    input  logic [ADDR_BITS-1:0] host_addr_i,
    input  logic [WIDTH_M2D-1:0] host_data_i,
    input  logic                 host_start_i,
    output logic                 host_busy_o,
    input  logic                 duwrite_i,
    output logic [WIDTH_M2D-1:0] m2d_data_o,
    output logic                 m2d_valid_o,
    output logic                 m2d_rwbit_o,
    output logic [ADDR_BITS-1:0] words_sent_o,
    output logic                 job_done_o
);
    typedef enum logic [1:0] {IDLE, PRIME, SEND, DONE} state_t;
    localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH_WORDS - 1);
    state_t                 state;
    logic [WIDTH_M2D-1:0]   mem [DEPTH_WORDS];
    logic [ADDR_BITS-1:0]   ptr;
    logic [2*WIDTH_M2D-1:0] nonce_next;
    assign nonce_next = {mem[NONCE_HI_IDX], mem[NONCE_HI_IDX+1]} + 1'b1;
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
            ptr          <= '0;
            m2d_data_o   <= '0;
            m2d_valid_o  <= 1'b0;
            m2d_rwbit_o  <= 1'b0;
            host_busy_o  <= 1'b0;
            words_sent_o <= '0;
            job_done_o   <= 1'b0;
        end else begin
            job_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    // the buffer is only writable here, so it is frozen for the whole job
                    if (host_we_i && host_addr_i <= LAST) mem[host_addr_i] <= host_data_i;
                    if (host_start_i) begin
                        state       <= PRIME;
                        host_busy_o <= 1'b1;
                    end
                end
                PRIME: begin
                    m2d_data_o   <= mem[0];
                    m2d_valid_o  <= 1'b1;
                    m2d_rwbit_o  <= 1'b1;
                    ptr          <= '0;
                    words_sent_o <= '0;
                    state        <= SEND;
                end
                SEND: begin
                    if (m2d_valid_o && duwrite_i) begin
                        ptr          <= ptr + 1'b1;
                        words_sent_o <= words_sent_o + 1'b1;
                        // raise job_done now so it is high exactly while in DONE
                        if (ptr == LAST) begin
                            m2d_valid_o <= 1'b0;
                            m2d_rwbit_o <= 1'b0;
                            job_done_o  <= 1'b1;
                            state       <= DONE;
                        end else begin
                            m2d_data_o <= mem[ptr + 1'b1];
                        end
                    end
                end
                DONE: begin
                    if (AUTO_INC != 0) begin
                        mem[NONCE_HI_IDX]   <= nonce_next[2*WIDTH_M2D-1:WIDTH_M2D];
                        mem[NONCE_HI_IDX+1] <= nonce_next[WIDTH_M2D-1:0];
                    end
                    host_busy_o <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_work_feeder.sv
// tb_work_feeder: randomized self-checking bench for work_feeder against a buffer-level reference model.
module tb_work_feeder;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        host_we_i = 1'b0;
    logic [5:0]  host_addr_i = '0;
    logic [15:0] host_data_i = '0;
    logic        host_start_i = 1'b0;
    logic        host_busy_o;
    logic        duwrite_i = 1'b0;
    logic [15:0] m2d_data_o;
    logic        m2d_valid_o;
    logic        m2d_rwbit_o;
    logic [5:0]  words_sent_o;
    logic        job_done_o;

    int checks = 0;
    int errors = 0;
    logic [15:0] mdl [40];
    logic [15:0] got [$];
    int done_cnt, stall_err, lat, done_cyc, busy_cyc;

    work_feeder dut (
        .clk_i(clk_i), .rst_i(rst_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
        .host_data_i(host_data_i), .host_start_i(host_start_i), .host_busy_o(host_busy_o),
        .duwrite_i(duwrite_i), .m2d_data_o(m2d_data_o), .m2d_valid_o(m2d_valid_o),
        .m2d_rwbit_o(m2d_rwbit_o), .words_sent_o(words_sent_o), .job_done_o(job_done_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #3000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // reference model: the buffer as the host sees it
    task automatic mdl_write(input int a, input logic [15:0] d);
        if (a < 40) mdl[a] = d;
    endtask

    task automatic mdl_nonce_inc();
        logic [31:0] v;
        v = {mdl[38], mdl[39]} + 32'd1;
        mdl[38] = v[31:16];
        mdl[39] = v[15:0];
    endtask

    task automatic mdl_clear();
        for (int i = 0; i < 40; i++) mdl[i] = '0;
    endtask

    function automatic int count_bad();
        int b = 0;
        for (int i = 0; i < got.size() && i < 40; i++) if (got[i] !== mdl[i]) b++;
        return b;
    endfunction

    // all tasks enter and leave one time unit after a rising edge
    task automatic host_write(input logic [5:0] a, input logic [15:0] d);
        host_we_i = 1'b1; host_addr_i = a; host_data_i = d;
        @(posedge clk_i); #1;
        host_we_i = 1'b0;
    endtask

    task automatic run_job(input int pct, input bit inj, input int stop_after);
        logic [15:0] held;
        bit stalled;
        got.delete();
        done_cnt = 0; stall_err = 0; lat = -1; done_cyc = -1; busy_cyc = -1;
        stalled = 0; held = '0;
        host_start_i = 1'b1;
        @(posedge clk_i); #1;
        host_start_i = 1'b0; host_we_i = 1'b0;
        for (int n = 1; n < 800; n++) begin
            duwrite_i = ($urandom_range(99) < pct);
            if (inj && n == 6) begin
                host_we_i = 1'b1; host_addr_i = 6'd5; host_data_i = 16'hDEAD; host_start_i = 1'b1;
            end
            @(negedge clk_i);
            if (stalled && m2d_data_o !== held) stall_err++;
            stalled = m2d_valid_o && !duwrite_i;
            held = m2d_data_o;
            if (m2d_valid_o && lat < 0) lat = n;
            if (m2d_valid_o && duwrite_i) got.push_back(m2d_data_o);
            if (job_done_o) begin done_cnt++; done_cyc = n; end
            if (!host_busy_o && busy_cyc < 0) busy_cyc = n;
            @(posedge clk_i); #1;
            host_we_i = 1'b0; host_start_i = 1'b0;
            if (stop_after > 0 && got.size() == stop_after) break;
            if (busy_cyc >= 0) break;
        end
        duwrite_i = 1'b0;
    endtask

    task automatic test_reset();
        host_write(6'd0, 16'hABCD);
        host_start_i = 1'b1;
        @(posedge clk_i); #1;
        host_start_i = 1'b0;
        duwrite_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (m2d_valid_o !== 1'b1 || m2d_data_o !== 16'hABCD) begin
            errors++; $display("FAIL pre_reset_word got v=%b d=%h exp v=1 d=abcd", m2d_valid_o, m2d_data_o);
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if ({m2d_valid_o, m2d_rwbit_o, host_busy_o, job_done_o, words_sent_o, m2d_data_o} !== '0) begin
            errors++;
            $display("FAIL async_reset_outputs got v=%b rw=%b busy=%b done=%b ws=%0d d=%h exp all zero",
                     m2d_valid_o, m2d_rwbit_o, host_busy_o, job_done_o, words_sent_o, m2d_data_o);
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        mdl_clear();
        run_job(100, 0, 0);
        checks++;
        if (got.size() !== 40 || count_bad() !== 0) begin
            errors++; $display("FAIL reset_zero_stream got n=%0d bad=%0d exp n=40 bad=0", got.size(), count_bad());
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL reset_job_done got %0d exp 1", done_cnt);
        end
        mdl_nonce_inc();
    endtask

    task automatic test_basic_stream();
        for (int i = 0; i < 40; i++) begin
            host_write(6'(i), 16'(16'h1000 + i));
            mdl_write(i, 16'(16'h1000 + i));
        end
        run_job(100, 0, 0);
        checks++;
        if (got.size() !== 40) begin
            errors++; $display("FAIL basic_count got %0d exp 40", got.size());
        end
        checks++;
        if (count_bad() !== 0 || got[39] !== 16'h1027) begin
            errors++; $display("FAIL basic_order got bad=%0d exp 0", count_bad());
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL basic_first_valid_latency got %0d exp 2", lat);
        end
        checks++;
        if (done_cnt !== 1 || done_cyc !== 42) begin
            errors++; $display("FAIL basic_job_done got cnt=%0d cyc=%0d exp cnt=1 cyc=42", done_cnt, done_cyc);
        end
        checks++;
        if (busy_cyc !== 43) begin
            errors++; $display("FAIL basic_busy_fall got %0d exp 43", busy_cyc);
        end
        checks++;
        if (words_sent_o !== 6'd40 || m2d_rwbit_o !== 1'b0 || m2d_valid_o !== 1'b0) begin
            errors++; $display("FAIL basic_end_state got ws=%0d rw=%b v=%b exp 40 0 0", words_sent_o, m2d_rwbit_o, m2d_valid_o);
        end
        mdl_nonce_inc();
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 40; i++) begin
                logic [15:0] d;
                d = 16'($urandom);
                host_write(6'(i), d);
                mdl_write(i, d);
            end
            run_job(25 + 25 * k, 0, 0);
            checks++;
            if (got.size() !== 40 || count_bad() !== 0) begin
                errors++; $display("FAIL bp_stream_%0d got n=%0d bad=%0d exp n=40 bad=0", k, got.size(), count_bad());
            end
            checks++;
            if (stall_err !== 0) begin
                errors++; $display("FAIL bp_hold_stable_%0d got %0d changes exp 0", k, stall_err);
            end
            checks++;
            if (done_cnt !== 1 || words_sent_o !== 6'd40) begin
                errors++; $display("FAIL bp_done_%0d got cnt=%0d ws=%0d exp 1 40", k, done_cnt, words_sent_o);
            end
            mdl_nonce_inc();
        end
    endtask

    task automatic test_nonce_wrap();
        host_write(6'd38, 16'hFFFF); mdl_write(38, 16'hFFFF);
        host_write(6'd39, 16'hFFFF); mdl_write(39, 16'hFFFF);
        run_job(100, 0, 0);
        checks++;
        if (got.size() !== 40 || got[38] !== 16'hFFFF || got[39] !== 16'hFFFF || count_bad() !== 0) begin
            errors++; $display("FAIL nonce_job1 got n=%0d bad=%0d exp n=40 FFFF/FFFF", got.size(), count_bad());
        end
        mdl_nonce_inc();
        run_job(100, 0, 0);
        checks++;
        if (got.size() !== 40 || got[38] !== 16'h0000 || got[39] !== 16'h0000 || count_bad() !== 0) begin
            errors++; $display("FAIL nonce_wrap got n=%0d bad=%0d exp n=40 0000/0000", got.size(), count_bad());
        end
        mdl_nonce_inc();
        host_write(6'd39, 16'h00FF); mdl_write(39, 16'h00FF);
        run_job(70, 0, 0);
        mdl_nonce_inc();
        run_job(100, 0, 0);
        checks++;
        if (got.size() !== 40 || got[38] !== 16'h0000 || got[39] !== 16'h0100 || count_bad() !== 0) begin
            errors++; $display("FAIL nonce_carry got n=%0d bad=%0d exp n=40 0000/0100", got.size(), count_bad());
        end
        mdl_nonce_inc();
    endtask

    task automatic test_guards();
        host_write(6'd45, 16'hBEEF); mdl_write(45, 16'hBEEF);
        host_write(6'd5, 16'h5555); mdl_write(5, 16'h5555);
        // write to addr 7 in the same cycle as start must appear in the stream
        host_we_i = 1'b1; host_addr_i = 6'd7; host_data_i = 16'h7777;
        mdl_write(7, 16'h7777);
        run_job(100, 1, 0);
        checks++;
        if (got.size() !== 40 || count_bad() !== 0) begin
            errors++; $display("FAIL guard_stream got n=%0d bad=%0d exp n=40 bad=0", got.size(), count_bad());
        end
        checks++;
        if (got.size() == 40 && (got[5] !== 16'h5555 || got[7] !== 16'h7777)) begin
            errors++; $display("FAIL guard_words got w5=%h w7=%h exp 5555 7777", got[5], got[7]);
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++; $display("FAIL guard_done got %0d exp 1", done_cnt);
        end
        mdl_nonce_inc();
        duwrite_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            checks++;
            if (host_busy_o !== 1'b0 || m2d_valid_o !== 1'b0) begin
                errors++; $display("FAIL guard_no_second_job got busy=%b v=%b exp 0 0", host_busy_o, m2d_valid_o);
            end
        end
        @(posedge clk_i); #1;
        duwrite_i = 1'b0;
        run_job(100, 0, 0);
        checks++;
        if (got.size() !== 40 || count_bad() !== 0) begin
            errors++; $display("FAIL guard_buffer_after got n=%0d bad=%0d exp n=40 bad=0", got.size(), count_bad());
        end
        mdl_nonce_inc();
    endtask

    task automatic test_reset_mid_job();
        int dn;
        for (int i = 0; i < 40; i++) begin
            logic [15:0] d;
            d = 16'($urandom) | 16'h0001;
            host_write(6'(i), d);
            mdl_write(i, d);
        end
        run_job(60, 0, 10);
        checks++;
        if (got.size() !== 10 || count_bad() !== 0) begin
            errors++; $display("FAIL midrst_prefix got n=%0d bad=%0d exp n=10 bad=0", got.size(), count_bad());
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (m2d_valid_o !== 1'b0 || host_busy_o !== 1'b0 || words_sent_o !== 6'd0) begin
            errors++; $display("FAIL midrst_clear got v=%b busy=%b ws=%0d exp 0 0 0", m2d_valid_o, host_busy_o, words_sent_o);
        end
        dn = 0;
        repeat (3) begin
            @(negedge clk_i);
            if (job_done_o) dn++;
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        if (job_done_o) dn++;
        checks++;
        if (dn !== 0) begin
            errors++; $display("FAIL midrst_no_done got %0d pulses exp 0", dn);
        end
        @(posedge clk_i); #1;
        mdl_clear();
        run_job(100, 0, 0);
        checks++;
        if (got.size() !== 40 || count_bad() !== 0) begin
            errors++; $display("FAIL midrst_fresh_stream got n=%0d bad=%0d exp n=40 bad=0", got.size(), count_bad());
        end
        checks++;
        if (done_cnt !== 1 || words_sent_o !== 6'd40) begin
            errors++; $display("FAIL midrst_fresh_done got cnt=%0d ws=%0d exp 1 40", done_cnt, words_sent_o);
        end
        mdl_nonce_inc();
    endtask

    initial begin
        mdl_clear();
        repeat (2) @(posedge clk_i);
        #1;
        checks++;
        if ({m2d_valid_o, m2d_rwbit_o, host_busy_o, job_done_o, words_sent_o, m2d_data_o} !== '0) begin
            errors++; $display("FAIL power_on_reset got v=%b busy=%b d=%h exp zeros", m2d_valid_o, host_busy_o, m2d_data_o);
        end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_nonce_wrap();
        test_guards();
        test_reset_mid_job();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
